control_sequencer: RTL and testbench
====================================

# control_sequencer

Micro-coded control sequencer for the 8-bit CPU. It is the consumer-side counterpart of the bus controller. Each step it chooses which single source drives the shared bus (CO, IO, AO, SO, RO) and which registers load from the bus (MI, RI, II, AI, BI, OI) in the same cycle. It also raises PC increment, jump, subtract and halt strobes. It steps a T-state counter through fetch and execute phases, decoding the instruction register opcode and ALU flags.

## Interface
Parameters:
- OP_W, 4, opcode width (upper nibble of instruction register); fixed at 4 for this ISA
- STEP_W, 3, T-state counter width; must hold values 0..4

Ports:
- clock  input  1  rising-edge clock for all state
- reset  input  1  synchronous, active-high reset
- opcode  input  OP_W  instruction register bits [7:4]; valid from T2 onward
- flagC  input  1  ALU carry flag, registered externally
- flagZ  input  1  ALU zero flag, registered externally
- CO, IO, AO, SO, RO  output  1 each  bus drive enables (PC, instr reg, reg A, ALU, RAM)
- MI, RI, II, AI, BI, OI  output  1 each  bus load enables (MAR, RAM write, instr reg, reg A, reg B, output reg)
- CE  output  1  PC increment
- J  output  1  PC load from bus
- SU  output  1  ALU subtract select
- HLT  output  1  halt indication
- tstate  output  STEP_W  current step, for debug LEDs

## Operation
- State: step register (0..4) and halted flag.
- Outputs are combinational decodes of step, halted, opcode and flags.
- Fetch, identical for all opcodes:
  - T0: CO, MI
  - T1: RO, II, CE
- Execute by opcode. Each instruction ends after its last listed step, and the next cycle is T0.
  - 0x1 LDA: T2 IO,MI; T3 RO,AI (length 4)
  - 0x2 ADD: T2 IO,MI; T3 RO,BI; T4 SO,AI (length 5)
  - 0x3 SUB: as ADD, with SU high in T4 only (length 5)
  - 0x4 STA: T2 IO,MI; T3 AO,RI (length 4)
  - 0x5 LDI: T2 IO,AI (length 3)
  - 0x6 JMP: T2 IO,J (length 3)
  - 0x7 JC: T2 IO, plus J only if flagC=1 (length 3 regardless of flag)
  - 0x8 JZ: T2 IO, plus J only if flagZ=1 (length 3)
  - 0xE OUT: T2 AO,OI (length 3)
  - 0xF HLT: T2 HLT; the next edge sets halted (length n/a)
  - 0x0 and all other undefined opcodes: T2 no signals (length 3)
- Invariant: at most one of CO/IO/AO/SO/RO is high in any cycle, including during reset and halt.
- Halted state:
  - All outputs 0 except HLT=1.
  - step is frozen at 2 and tstate reads 2.
  - Only reset exits the halted state.

## Timing
- Reset:
  - A clock edge with reset=1 sets step=0 and halted=0.
  - While reset=1, every control output is forced 0 combinationally; tstate reads 0.
  - The first cycle after reset deasserts presents T0 (CO, MI high).
- Reset mid-instruction, at any step or while halted: the above applies on that edge. No partial micro-op completes afterwards.
- Step advance: step increments on each rising edge. It returns to 0 on the edge ending the instruction's last step, so there are no idle cycles between instructions.
- Opcode and flags are sampled combinationally during T2..T4 only; their values in T0/T1 are ignored.
- Flags are not latched by this block, so a flag change inside T2 affects J in that cycle.
- Wrap: step never exceeds 4. A length-5 instruction returns from 4 to 0.
- Latency (cycles): LDI/JMP/JC/JZ/OUT/NOP 3, LDA/STA 4, ADD/SUB 5. HLT reaches the halted state on the edge ending T2.

## Test plan
- Reset then LDA: hold reset 2 cycles, release with opcode=0x1.
  - Outputs must be all 0 during reset.
  - Then, one cycle each: {CO,MI}, {RO,II,CE}, {IO,MI}, {RO,AI}, then back to {CO,MI}.
  - tstate reads 0,1,2,3,0.
- ADD vs SUB:
  - opcode=0x2: T4 = {SO,AI}, SU=0, 5-cycle period.
  - opcode=0x3: T4 = {SO,AI,SU}.
- Conditional jumps:
  - opcode=0x7 with flagC=0: T2 = {IO} only.
  - opcode=0x7 with flagC=1: T2 = {IO,J}.
  - Repeat for 0x8 with flagZ; tstate returns to 0 after T2 in all four cases.
- Halt:
  - opcode=0xF: T2 shows HLT.
  - For 10 further cycles: HLT=1, all other outputs 0, tstate=2.
  - Assert reset: next cycle all 0; after release, T0 {CO,MI}.
- Mid-instruction reset: assert reset during T3 of ADD; outputs 0 immediately, tstate=0 after the edge, and no SO/AI ever appears.
- Contention sweep: random opcodes, flags and reset for 2000 cycles. Check every cycle:
  - At most one bus drive enable is high.
  - tstate is never >4.
  - Each instruction period matches the length table.

Source files
------------

// File: rtl/control_sequencer.sv
// Micro-coded control sequencer for the 8-bit CPU: steps T0..T4 through fetch/execute
// and decodes opcode and flags into bus drive, bus load and PC/ALU strobes.
module control_sequencer #(
  parameter int OP_W   = 4,
  parameter int STEP_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [OP_W-1:0]   opcode,
  input  logic              flagC,
  input  logic              flagZ,
  output logic              CO,
  output logic              IO,
  output logic              AO,
  output logic              SO,
  output logic              RO,
  output logic              MI,
  output logic              RI,
  output logic              II,
  output logic              AI,
  output logic              BI,
  output logic              OI,
  output logic              CE,
  output logic              J,
  output logic              SU,
  output logic              HLT,
  output logic [STEP_W-1:0] tstate
);

  typedef enum logic [STEP_W-1:0] {
    T0 = STEP_W'(0),
    T1 = STEP_W'(1),
    T2 = STEP_W'(2),
    T3 = STEP_W'(3),
    T4 = STEP_W'(4)
  } step_t;

  localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'h1);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'h2);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'h3);
  localparam logic [OP_W-1:0] OP_STA = OP_W'(4'h4);
  localparam logic [OP_W-1:0] OP_LDI = OP_W'(4'h5);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(4'h6);
  localparam logic [OP_W-1:0] OP_JC  = OP_W'(4'h7);
  localparam logic [OP_W-1:0] OP_JZ  = OP_W'(4'h8);
  localparam logic [OP_W-1:0] OP_OUT = OP_W'(4'hE);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'hF);

  step_t step, step_nxt;
  logic  halted, halted_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      step   <= T0;
      halted <= 1'b0;
    end else begin
      step   <= step_nxt;
      halted <= halted_nxt;
    end
  end

  always_comb begin
    {CO, IO, AO, SO, RO, MI, RI, II, AI, BI, OI, CE, J, SU, HLT} = '0;
    step_nxt   = step;
    halted_nxt = halted;

    if (halted) begin
      HLT = 1'b1;
    end else begin
      case (step)
        T0: begin
          CO = 1'b1; MI = 1'b1;
          step_nxt = T1;
        end
        T1: begin
          RO = 1'b1; II = 1'b1; CE = 1'b1;
          step_nxt = T2;
        end
        T2: begin
          // Only the two- and three-step execute opcodes continue past T2.
          step_nxt = T0;
          case (opcode)
            OP_LDA, OP_STA: begin IO = 1'b1; MI = 1'b1; step_nxt = T3; end
            OP_ADD, OP_SUB: begin IO = 1'b1; MI = 1'b1; step_nxt = T3; end
            OP_LDI: begin IO = 1'b1; AI = 1'b1; end
            OP_JMP: begin IO = 1'b1; J = 1'b1; end
            OP_JC:  begin IO = 1'b1; J = flagC; end
            OP_JZ:  begin IO = 1'b1; J = flagZ; end
            OP_OUT: begin AO = 1'b1; OI = 1'b1; end
            OP_HLT: begin HLT = 1'b1; halted_nxt = 1'b1; step_nxt = T2; end
            default: ;
          endcase
        end
        T3: begin
          step_nxt = T0;
          case (opcode)
            OP_LDA: begin RO = 1'b1; AI = 1'b1; end
            OP_STA: begin AO = 1'b1; RI = 1'b1; end
            OP_ADD, OP_SUB: begin RO = 1'b1; BI = 1'b1; step_nxt = T4; end
            default: ;
          endcase
        end
        T4: begin
          step_nxt = T0;
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            SO = 1'b1; AI = 1'b1;
            SU = (opcode == OP_SUB);
          end
        end
        default: step_nxt = T0;
      endcase
    end

    // Reset silences every strobe in the same cycle, including while halted.
    if (reset) begin
      {CO, IO, AO, SO, RO, MI, RI, II, AI, BI, OI, CE, J, SU, HLT} = '0;
    end
  end

  assign tstate = reset ? '0 : step;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed-vector bench for control_sequencer: a cycle table, hand sequences for halt
// and mid-instruction reset, and a reference-model sweep with random inputs.
module tb_control_sequencer;

  logic       clock;
  logic       reset;
  logic [3:0] opcode;
  logic       flagC, flagZ;
  logic       CO, IO, AO, SO, RO, MI, RI, II, AI, BI, OI, CE, J, SU, HLT;
  logic [2:0] tstate;
  logic [14:0] ctrl;

  control_sequencer #(.OP_W(4), .STEP_W(3)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .flagC(flagC), .flagZ(flagZ),
    .CO(CO), .IO(IO), .AO(AO), .SO(SO), .RO(RO),
    .MI(MI), .RI(RI), .II(II), .AI(AI), .BI(BI), .OI(OI),
    .CE(CE), .J(J), .SU(SU), .HLT(HLT), .tstate(tstate)
  );

  assign ctrl = {CO, IO, AO, SO, RO, MI, RI, II, AI, BI, OI, CE, J, SU, HLT};

  localparam logic [14:0] C_CO = 15'h4000, C_IO = 15'h2000, C_AO = 15'h1000;
  localparam logic [14:0] C_SO = 15'h0800, C_RO = 15'h0400, C_MI = 15'h0200;
  localparam logic [14:0] C_RI = 15'h0100, C_II = 15'h0080, C_AI = 15'h0040;
  localparam logic [14:0] C_BI = 15'h0020, C_OI = 15'h0010, C_CE = 15'h0008;
  localparam logic [14:0] C_J  = 15'h0004, C_SU = 15'h0002, C_HLT = 15'h0001;
  localparam logic [14:0] F0 = C_CO | C_MI;
  localparam logic [14:0] F1 = C_RO | C_II | C_CE;

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        r;
    logic [3:0]  op;
    logic        c;
    logic        z;
    logic [14:0] ctrl;
    logic [2:0]  ts;
  } vec_t;

  vec_t vecs[$];
  int   tests  = 0;
  int   failed = 0;

  // driver tasks
  task automatic add(input logic r, input logic [3:0] op, input logic c, input logic z,
                     input logic [14:0] e, input logic [2:0] ts);
    vec_t v;
    v.r = r; v.op = op; v.c = c; v.z = z; v.ctrl = e; v.ts = ts;
    vecs.push_back(v);
  endtask

  task automatic fetch(input logic [3:0] op, input logic c, input logic z);
    add(1'b0, op, c, z, F0, 3'd0);
    add(1'b0, op, c, z, F1, 3'd1);
  endtask

  task automatic apply(input logic r, input logic [3:0] op, input logic c, input logic z);
    @(negedge clock);
    reset = r; opcode = op; flagC = c; flagZ = z;
    #1;
  endtask

  task automatic check(input string name, input logic [14:0] e, input logic [2:0] ts);
    tests++;
    if (ctrl !== e || tstate !== ts) begin
      failed++;
      $display("FAIL %s: ctrl=%h tstate=%0d, expected ctrl=%h tstate=%0d",
               name, ctrl, tstate, e, ts);
    end
  endtask

  // reference model for the random sweep
  function automatic logic [14:0] model_ctrl(input logic r, input logic h, input logic [2:0] s,
                                             input logic [3:0] op, input logic c, input logic z);
    logic [14:0] e;
    e = '0;
    if (r) return '0;
    if (h) return C_HLT;
    case (s)
      3'd0: e = F0;
      3'd1: e = F1;
      3'd2: case (op)
        4'h1, 4'h2, 4'h3, 4'h4: e = C_IO | C_MI;
        4'h5: e = C_IO | C_AI;
        4'h6: e = C_IO | C_J;
        4'h7: e = c ? (C_IO | C_J) : C_IO;
        4'h8: e = z ? (C_IO | C_J) : C_IO;
        4'hE: e = C_AO | C_OI;
        4'hF: e = C_HLT;
        default: e = '0;
      endcase
      3'd3: case (op)
        4'h1: e = C_RO | C_AI;
        4'h2, 4'h3: e = C_RO | C_BI;
        4'h4: e = C_AO | C_RI;
        default: e = '0;
      endcase
      3'd4: case (op)
        4'h2: e = C_SO | C_AI;
        4'h3: e = C_SO | C_AI | C_SU;
        default: e = '0;
      endcase
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic int instr_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
  endfunction

  logic [2:0] es;
  logic       eh;
  int         run_len;
  logic       run_valid;
  logic [3:0] run_op;
  logic       r_rand;

  initial begin
    reset = 1'b1; opcode = 4'h1; flagC = 1'b0; flagZ = 1'b0;

    // table: reset then every opcode back to back
    add(1'b1, 4'h1, 1'b0, 1'b0, '0, 3'd0);
    add(1'b1, 4'h1, 1'b1, 1'b1, '0, 3'd0);
    fetch(4'h1, 1'b0, 1'b0);
    add(1'b0, 4'h1, 1'b0, 1'b0, C_IO | C_MI, 3'd2);
    add(1'b0, 4'h1, 1'b0, 1'b0, C_RO | C_AI, 3'd3);
    fetch(4'h2, 1'b1, 1'b1);
    add(1'b0, 4'h2, 1'b0, 1'b0, C_IO | C_MI, 3'd2);
    add(1'b0, 4'h2, 1'b0, 1'b0, C_RO | C_BI, 3'd3);
    add(1'b0, 4'h2, 1'b0, 1'b0, C_SO | C_AI, 3'd4);
    fetch(4'h3, 1'b0, 1'b0);
    add(1'b0, 4'h3, 1'b0, 1'b0, C_IO | C_MI, 3'd2);
    add(1'b0, 4'h3, 1'b0, 1'b0, C_RO | C_BI, 3'd3);
    add(1'b0, 4'h3, 1'b0, 1'b0, C_SO | C_AI | C_SU, 3'd4);
    fetch(4'h7, 1'b1, 1'b0);
    add(1'b0, 4'h7, 1'b0, 1'b1, C_IO, 3'd2);
    fetch(4'h7, 1'b0, 1'b0);
    add(1'b0, 4'h7, 1'b1, 1'b0, C_IO | C_J, 3'd2);
    fetch(4'h8, 1'b0, 1'b1);
    add(1'b0, 4'h8, 1'b1, 1'b0, C_IO, 3'd2);
    fetch(4'h8, 1'b0, 1'b0);
    add(1'b0, 4'h8, 1'b0, 1'b1, C_IO | C_J, 3'd2);
    fetch(4'h4, 1'b0, 1'b0);
    add(1'b0, 4'h4, 1'b0, 1'b0, C_IO | C_MI, 3'd2);
    add(1'b0, 4'h4, 1'b0, 1'b0, C_AO | C_RI, 3'd3);
    fetch(4'h5, 1'b0, 1'b0);
    add(1'b0, 4'h5, 1'b0, 1'b0, C_IO | C_AI, 3'd2);
    fetch(4'hE, 1'b0, 1'b0);
    add(1'b0, 4'hE, 1'b0, 1'b0, C_AO | C_OI, 3'd2);
    fetch(4'h0, 1'b0, 1'b0);
    add(1'b0, 4'h0, 1'b1, 1'b1, '0, 3'd2);
    fetch(4'hA, 1'b0, 1'b0);
    add(1'b0, 4'hA, 1'b0, 1'b0, '0, 3'd2);
    fetch(4'h6, 1'b0, 1'b0);
    add(1'b0, 4'h6, 1'b0, 1'b0, C_IO | C_J, 3'd2);
    add(1'b0, 4'h1, 1'b0, 1'b0, F0, 3'd0);

    foreach (vecs[i]) begin
      apply(vecs[i].r, vecs[i].op, vecs[i].c, vecs[i].z);
      check($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].ts);
    end

    // halt: frozen at T2 until reset
    apply(1'b1, 4'hF, 1'b0, 1'b0); check("halt_rst", '0, 3'd0);
    apply(1'b0, 4'hF, 1'b0, 1'b0); check("halt_t0", F0, 3'd0);
    apply(1'b0, 4'hF, 1'b0, 1'b0); check("halt_t1", F1, 3'd1);
    apply(1'b0, 4'hF, 1'b0, 1'b0); check("halt_t2", C_HLT, 3'd2);
    for (int k = 0; k < 10; k++) begin
      apply(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check($sformatf("halted%0d", k), C_HLT, 3'd2);
    end
    apply(1'b1, 4'h1, 1'b0, 1'b0); check("halt_exit_rst", '0, 3'd0);
    apply(1'b0, 4'h1, 1'b0, 1'b0); check("halt_exit_t0", F0, 3'd0);

    // reset during T3 of ADD
    apply(1'b1, 4'h2, 1'b0, 1'b0); check("mid_rst0", '0, 3'd0);
    apply(1'b0, 4'h2, 1'b0, 1'b0); check("mid_t0", F0, 3'd0);
    apply(1'b0, 4'h2, 1'b0, 1'b0); check("mid_t1", F1, 3'd1);
    apply(1'b0, 4'h2, 1'b0, 1'b0); check("mid_t2", C_IO | C_MI, 3'd2);
    apply(1'b0, 4'h2, 1'b0, 1'b0); check("mid_t3", C_RO | C_BI, 3'd3);
    reset = 1'b1; #1; check("mid_rst_comb", '0, 3'd0);
    apply(1'b0, 4'h2, 1'b0, 1'b0); check("mid_after_t0", F0, 3'd0);
    apply(1'b0, 4'h2, 1'b0, 1'b0); check("mid_after_t1", F1, 3'd1);

    // random sweep against the reference model
    apply(1'b1, 4'h0, 1'b0, 1'b0); check("sweep_rst", '0, 3'd0);
    es = 3'd0; eh = 1'b0; run_len = 0; run_valid = 1'b0; run_op = 4'h0;
    for (int n = 0; n < 2000; n++) begin
      r_rand = eh ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 39) == 0);
      apply(r_rand, (es < 3'd2) ? 4'($urandom_range(0, 15)) : opcode,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check($sformatf("sweep%0d", n), model_ctrl(reset, eh, es, opcode, flagC, flagZ),
            reset ? 3'd0 : es);
      tests++;
      if ($countones(ctrl[14:10]) > 1 || tstate > 3'd4) begin
        failed++;
        $display("FAIL sweep_bus%0d: drives=%b tstate=%0d, expected <=1 drive and tstate<=4",
                 n, ctrl[14:10], tstate);
      end
      if (reset || eh) begin
        run_valid = 1'b0;
      end else begin
        if (tstate == 3'd0) begin
          if (run_valid) begin
            tests++;
            if (run_len != instr_len(run_op)) begin
              failed++;
              $display("FAIL sweep_len%0d: op=%h period=%0d, expected %0d",
                       n, run_op, run_len, instr_len(run_op));
            end
          end
          run_len = 1; run_valid = 1'b1;
        end else begin
          run_len++;
        end
        if (tstate == 3'd2) run_op = opcode;
      end
      // advance model
      if (reset) begin
        es = 3'd0; eh = 1'b0;
      end else if (!eh) begin
        if (es == 3'd2 && opcode == 4'hF) eh = 1'b1;
        else if (es >= 3'd2 && (32'(es) + 1 == instr_len(opcode) || es == 3'd4)) es = 3'd0;
        else es = es + 3'd1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
